// File: rtl/memory_stage_pkg.sv
// memory_stage_pkg
// Shared definitions for the Lucid64 memory stage:
//   - XLEN, the datapath width
//   - one-hot access-width codes (MEM_WIDTH_1H_*)
//   - one-hot rd-source codes (RD_SRC_1H_*)
//   - memory-stage FSM state type (MEM_ST_*)
//   - width_mask(): the unshifted byte-enable pattern for an access width
package memory_stage_pkg;

   localparam int XLEN = 64;

   localparam logic [3:0] MEM_WIDTH_1H_B = 4'b0001;
   localparam logic [3:0] MEM_WIDTH_1H_H = 4'b0010;
   localparam logic [3:0] MEM_WIDTH_1H_W = 4'b0100;
   localparam logic [3:0] MEM_WIDTH_1H_D = 4'b1000;

   localparam logic [2:0] RD_SRC_1H_ALU = 3'b001;
   localparam logic [2:0] RD_SRC_1H_MEM = 3'b010;
   localparam logic [2:0] RD_SRC_1H_PC  = 3'b100;

   typedef enum logic [1:0] {
      MEM_ST_IDLE,
      MEM_ST_REQ,
      MEM_ST_RESP,
      MEM_ST_HOLD
   } mem_state_e;

   // Byte lanes covered by an access of the given width, starting at lane 0.
   // A width code that is not one-hot selects no lanes.
   function automatic logic [7:0] width_mask(input logic [3:0] width_1h);
      logic [7:0] mask;
      mask = 8'h00;
      case (width_1h)
         MEM_WIDTH_1H_B: mask = 8'h01;
         MEM_WIDTH_1H_H: mask = 8'h03;
         MEM_WIDTH_1H_W: mask = 8'h0F;
         MEM_WIDTH_1H_D: mask = 8'hFF;
         default:        mask = 8'h00;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/mem_align_unit.sv
// mem_align_unit
// Purely combinational lane steering for the memory stage.
// Ports:
//   offset      in   3  byte offset within the doubleword (addr[2:0])
//   width_1h    in   4  one-hot access width (B/H/W/D)
//   sign        in   1  sign-extend the load result
//   store_data  in  64  unaligned store data (rs2)
//   load_raw    in  64  full doubleword returned by the bus
//   byte_en     out  8  byte enables moved to the addressed lanes
//   store_lane  out 64  store data moved to the addressed lanes
//   load_data   out 64  addressed bytes moved to lane 0 and extended
//   misaligned  out  1  offset is not a multiple of the access size
module mem_align_unit
   import memory_stage_pkg::*;
(
   input  logic [2:0]      offset,
   input  logic [3:0]      width_1h,
   input  logic            sign,
   input  logic [XLEN-1:0] store_data,
   input  logic [XLEN-1:0] load_raw,
   output logic [7:0]      byte_en,
   output logic [XLEN-1:0] store_lane,
   output logic [XLEN-1:0] load_data,
   output logic            misaligned
);

   logic [5:0]      bit_shift;
   logic [XLEN-1:0] load_shift;

   assign bit_shift  = {offset, 3'b000};
   assign byte_en    = width_mask(width_1h) << offset;
   assign store_lane = store_data << bit_shift;
   assign load_shift = load_raw >> bit_shift;

   // Truncate the lane-0 load data to the access size and extend it back to
   // XLEN; the same width decode also flags offsets the access cannot use.
   // Doublewords need no extension, so the sign input is ignored for them.
   always_comb begin
      misaligned = 1'b0;
      load_data  = load_shift;
      case (width_1h)
         MEM_WIDTH_1H_B: begin
            load_data = {{56{sign & load_shift[7]}}, load_shift[7:0]};
         end
         MEM_WIDTH_1H_H: begin
            misaligned = offset[0];
            load_data  = {{48{sign & load_shift[15]}}, load_shift[15:0]};
         end
         MEM_WIDTH_1H_W: begin
            misaligned = |offset[1:0];
            load_data  = {{32{sign & load_shift[31]}}, load_shift[31:0]};
         end
         MEM_WIDTH_1H_D: begin
            misaligned = |offset;
            load_data  = load_shift;
         end
         default: begin
            misaligned = 1'b0;
            load_data  = load_shift;
         end
      endcase
   end

endmodule

// File: rtl/memory_stage.sv
// memory_stage
// Lucid64 memory stage between execute and writeback. Issues one load/store at
// a time on the request/grant/response data bus, steers store lanes, extracts
// and extends load data, stalls execute while the access is in flight and
// registers the result (which execute also uses for MEM forwarding).
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   stall_i / stall_o            hold from writeback / hold to execute
//   valid_i .. mem_sign_i        registered execute outputs
//   dmem_req_o .. dmem_rdata_i   data-memory bus
//   valid_o, rd_data_o, rd_idx_o, rd_wr_en_o, misaligned_o  registered result
module memory_stage
   import memory_stage_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stall_i,
   output logic        stall_o,
   input  logic        valid_i,
   input  logic [63:0] alu_res_i,
   input  logic [63:0] rs2_data_i,
   input  logic [63:0] rd_data_i,
   input  logic [4:0]  rd_idx_i,
   input  logic        rd_wr_en_i,
   input  logic [2:0]  rd_wr_src_1h_i,
   input  logic [3:0]  mem_width_1h_i,
   input  logic        mem_rd_i,
   input  logic        mem_wr_i,
   input  logic        mem_sign_i,
   output logic        dmem_req_o,
   input  logic        dmem_gnt_i,
   output logic        dmem_we_o,
   output logic [7:0]  dmem_be_o,
   output logic [63:0] dmem_addr_o,
   output logic [63:0] dmem_wdata_o,
   input  logic        dmem_rvalid_i,
   input  logic [63:0] dmem_rdata_i,
   output logic        valid_o,
   output logic [63:0] rd_data_o,
   output logic [4:0]  rd_idx_o,
   output logic        rd_wr_en_o,
   output logic        misaligned_o
);

   mem_state_e      state;
   mem_state_e      state_next;
   logic [XLEN-1:0] resp_buf;
   logic            mem_op;
   logic            offset_bad;
   logic            misaligned;
   logic            mem_go;
   logic            complete;
   logic [XLEN-1:0] load_raw;
   logic [XLEN-1:0] load_data;
   logic [XLEN-1:0] rd_value;

   assign mem_op     = valid_i & (mem_rd_i | mem_wr_i);
   assign misaligned = mem_op & offset_bad;
   assign mem_go     = mem_op & ~offset_bad;

   // Once the response has been parked in HOLD the bus data is no longer
   // valid, so the extractor reads the buffer instead.
   assign load_raw = (state == MEM_ST_HOLD) ? resp_buf : dmem_rdata_i;

   mem_align_unit u_align (
      .offset     (alu_res_i[2:0]),
      .width_1h   (mem_width_1h_i),
      .sign       (mem_sign_i),
      .store_data (rs2_data_i),
      .load_raw   (load_raw),
      .byte_en    (dmem_be_o),
      .store_lane (dmem_wdata_o),
      .load_data  (load_data),
      .misaligned (offset_bad)
   );

   // Execute is held while an access is in flight, so the request fields can
   // be driven straight from its registers and stay stable until the grant.
   assign dmem_addr_o = {alu_res_i[63:3], 3'b000};
   assign dmem_we_o   = mem_wr_i;

   assign rd_value = |(rd_wr_src_1h_i & RD_SRC_1H_MEM) ? load_data : rd_data_i;

   // Execute stays held until the cycle in which the result is written.
   assign stall_o = mem_go & ~complete;

   // State register for the single-outstanding bus transaction.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= MEM_ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and request logic. The first request cycle comes straight out
   // of IDLE so an immediately granted access costs no extra cycle. `complete`
   // marks the cycle whose edge writes the load/store result.
   always_comb begin
      state_next = state;
      dmem_req_o = 1'b0;
      complete   = 1'b0;
      case (state)
         MEM_ST_IDLE: begin
            if (mem_go) begin
               dmem_req_o = 1'b1;
               state_next = dmem_gnt_i ? MEM_ST_RESP : MEM_ST_REQ;
            end
         end
         MEM_ST_REQ: begin
            dmem_req_o = 1'b1;
            if (dmem_gnt_i) begin
               state_next = MEM_ST_RESP;
            end
         end
         MEM_ST_RESP: begin
            if (dmem_rvalid_i) begin
               if (stall_i) begin
                  state_next = MEM_ST_HOLD;
               end else begin
                  complete   = 1'b1;
                  state_next = MEM_ST_IDLE;
               end
            end
         end
         MEM_ST_HOLD: begin
            if (!stall_i) begin
               complete   = 1'b1;
               state_next = MEM_ST_IDLE;
            end
         end
         default: state_next = MEM_ST_IDLE;
      endcase
      if (rst_i) begin
         dmem_req_o = 1'b0;
      end
   end

   // Park the response when writeback is stalled on the cycle it arrives.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         resp_buf <= '0;
      end else if (state == MEM_ST_RESP && dmem_rvalid_i && stall_i) begin
         resp_buf <= dmem_rdata_i;
      end
   end

   // Result register: hold under downstream stall, insert a bubble while the
   // access is still outstanding, otherwise capture. Stores, misaligned
   // accesses and invalid slots never write rd.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_o      <= 1'b0;
         rd_data_o    <= '0;
         rd_idx_o     <= '0;
         rd_wr_en_o   <= 1'b0;
         misaligned_o <= 1'b0;
      end else if (stall_i) begin
         valid_o      <= valid_o;
      end else if (stall_o) begin
         valid_o      <= 1'b0;
         rd_wr_en_o   <= 1'b0;
      end else begin
         valid_o      <= valid_i;
         rd_data_o    <= rd_value;
         rd_idx_o     <= rd_idx_i;
         rd_wr_en_o   <= valid_i & rd_wr_en_i & ~mem_wr_i & ~misaligned;
         misaligned_o <= misaligned;
      end
   end

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage
// Drives whole instructions into memory_stage while acting as both execute and
// the data-memory bus. Each instruction carries its own bus timing (grant
// wait, response wait, writeback stall), from which the bench derives what
// every output must be on every cycle.
module tb_memory_stage;

   typedef struct {
      logic        valid;
      logic        rd;
      logic        wr;
      logic        sign;
      logic        wr_en;
      logic [3:0]  width;
      logic [2:0]  src;
      logic [4:0]  idx;
      logic [63:0] addr;
      logic [63:0] rs2;
      logic [63:0] rdv;
      logic [63:0] rdata;
      int          gnt_wait;
      int          resp_wait;
      int          hold;
   } op_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_down;
   logic        stall_up;
   logic        valid_in;
   logic [63:0] alu_res;
   logic [63:0] rs2_data;
   logic [63:0] rd_data_in;
   logic [4:0]  rd_idx_in;
   logic        rd_wr_en_in;
   logic [2:0]  rd_src;
   logic [3:0]  mem_width;
   logic        mem_rd;
   logic        mem_wr;
   logic        mem_sign;
   logic        req;
   logic        gnt;
   logic        we;
   logic [7:0]  be;
   logic [63:0] addr;
   logic [63:0] wdata;
   logic        rvalid;
   logic [63:0] rdata;
   logic        valid_out;
   logic [63:0] rd_data_out;
   logic [4:0]  rd_idx_out;
   logic        rd_wr_en_out;
   logic        misaligned_out;

   int errors = 0;
   int checks = 0;

   // expected values, checked at every falling edge while exp_check is set
   logic        exp_check = 1'b0;
   logic        exp_req, exp_stall, exp_we;
   logic [7:0]  exp_be;
   logic [63:0] exp_addr, exp_wdata;
   logic        mdl_valid, mdl_wr_en, mdl_mis, mdl_data_ok;
   logic [4:0]  mdl_idx;
   logic [63:0] mdl_data;

   // observations for the directed literal checks
   int          req_cycles = 0;
   int          stall_cycles = 0;
   logic [7:0]  seen_be;
   logic [63:0] seen_addr, seen_wdata;
   logic        seen_we;

   always #5 clk = ~clk;

   memory_stage dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .stall_i        (stall_down),
      .stall_o        (stall_up),
      .valid_i        (valid_in),
      .alu_res_i      (alu_res),
      .rs2_data_i     (rs2_data),
      .rd_data_i      (rd_data_in),
      .rd_idx_i       (rd_idx_in),
      .rd_wr_en_i     (rd_wr_en_in),
      .rd_wr_src_1h_i (rd_src),
      .mem_width_1h_i (mem_width),
      .mem_rd_i       (mem_rd),
      .mem_wr_i       (mem_wr),
      .mem_sign_i     (mem_sign),
      .dmem_req_o     (req),
      .dmem_gnt_i     (gnt),
      .dmem_we_o      (we),
      .dmem_be_o      (be),
      .dmem_addr_o    (addr),
      .dmem_wdata_o   (wdata),
      .dmem_rvalid_i  (rvalid),
      .dmem_rdata_i   (rdata),
      .valid_o        (valid_out),
      .rd_data_o      (rd_data_out),
      .rd_idx_o       (rd_idx_out),
      .rd_wr_en_o     (rd_wr_en_out),
      .misaligned_o   (misaligned_out)
   );

   function automatic int sizeOf(input logic [3:0] w);
      case (w)
         4'b0001: return 1;
         4'b0010: return 2;
         4'b0100: return 4;
         default: return 8;
      endcase
   endfunction

   function automatic logic [63:0] refLoad(input logic [63:0] raw, input int off,
                                           input int size, input logic sgn);
      logic [63:0] v;
      logic [63:0] m;
      v = raw >> (8 * off);
      if (size == 8) return v;
      m = (64'd1 << (8 * size)) - 64'd1;
      v = v & m;
      if (sgn && v[8 * size - 1]) v = v | ~m;
      return v;
   endfunction

   function automatic logic [7:0] refBe(input int off, input int size);
      int lanes;
      lanes = ((1 << size) - 1) << off;
      return 8'(lanes);
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of every output against the bench's expectations.
   always @(negedge clk) begin
      if (exp_check) begin
         checkOutput("stall_o", 64'(stall_up), 64'(exp_stall));
         checkOutput("dmem_req", 64'(req), 64'(exp_req));
         if (exp_req) begin
            checkOutput("dmem_addr", addr, exp_addr);
            checkOutput("dmem_be", 64'(be), 64'(exp_be));
            checkOutput("dmem_wdata", wdata, exp_wdata);
            checkOutput("dmem_we", 64'(we), 64'(exp_we));
         end
         checkOutput("valid_o", 64'(valid_out), 64'(mdl_valid));
         checkOutput("rd_wr_en_o", 64'(rd_wr_en_out), 64'(mdl_wr_en));
         checkOutput("misaligned_o", 64'(misaligned_out), 64'(mdl_mis));
         checkOutput("rd_idx_o", 64'(rd_idx_out), 64'(mdl_idx));
         if (mdl_data_ok) checkOutput("rd_data_o", rd_data_out, mdl_data);
      end
      if (req) begin
         req_cycles++;
         seen_be    = be;
         seen_addr  = addr;
         seen_wdata = wdata;
         seen_we    = we;
      end
      if (stall_up) stall_cycles++;
   end

   // Runs one instruction to completion. Cycle 0 is the cycle it enters the
   // stage. Aligned memory ops: grant in cycle gnt_wait, response resp_wait
   // cycles later, writeback stalled for `hold` cycles starting with the
   // response, result written at the end of cycle gnt_wait+resp_wait+hold.
   // Everything else: writeback stalled for the first `hold` cycles, result
   // written at the end of cycle `hold`.
   task automatic applyStimulus(input op_t op);
      logic mem_op, mis, aligned;
      int   size, off, done, rv;
      size    = sizeOf(op.width);
      off     = int'(op.addr[2:0]);
      mem_op  = op.valid && (op.rd || op.wr);
      mis     = mem_op && ((off % size) != 0);
      aligned = mem_op && !mis;
      rv      = op.gnt_wait + op.resp_wait;
      done    = aligned ? rv + op.hold : op.hold;
      for (int k = 0; k <= done; k++) begin
         valid_in    = op.valid;
         alu_res     = op.addr;
         rs2_data    = op.rs2;
         rd_data_in  = op.rdv;
         rd_idx_in   = op.idx;
         rd_wr_en_in = op.wr_en;
         rd_src      = op.src;
         mem_width   = op.width;
         mem_rd      = op.rd;
         mem_wr      = op.wr;
         mem_sign    = op.sign;
         gnt         = aligned && (k == op.gnt_wait);
         if (aligned && k == rv) begin
            rvalid = 1'b1;
            rdata  = op.rdata;
         end else begin
            // stray responses are only offered where no real one can be due
            rvalid = (!aligned || k < op.gnt_wait || k > rv) && ($urandom_range(0, 3) == 0);
            rdata  = {$urandom, $urandom};
         end
         stall_down = aligned ? (k >= rv && k < done) : (k < op.hold);
         exp_req    = aligned && (k <= op.gnt_wait);
         exp_stall  = aligned && (k < done);
         exp_addr   = {op.addr[63:3], 3'b000};
         exp_be     = refBe(off, size);
         exp_wdata  = op.rs2 << (8 * off);
         exp_we     = op.wr;
         @(posedge clk);
         #1;
         if (k == done) begin
            mdl_valid   = op.valid;
            mdl_idx     = op.idx;
            mdl_wr_en   = op.valid && op.wr_en && !op.wr && !mis;
            mdl_mis     = mis;
            mdl_data    = op.src[1] ? refLoad(op.rdata, off, size, op.sign) : op.rdv;
            mdl_data_ok = !mis;
         end else if (!stall_down) begin
            mdl_valid = 1'b0;
            mdl_wr_en = 1'b0;
         end
      end
      gnt    = 1'b0;
      rvalid = 1'b0;
   endtask

   function automatic op_t baseOp();
      op_t o;
      o.valid = 1'b1; o.rd = 1'b0; o.wr = 1'b0; o.sign = 1'b0; o.wr_en = 1'b1;
      o.width = 4'b1000; o.src = 3'b001; o.idx = 5'd1;
      o.addr = 64'd0; o.rs2 = 64'd0; o.rdv = 64'd0; o.rdata = 64'd0;
      o.gnt_wait = 0; o.resp_wait = 1; o.hold = 0;
      return o;
   endfunction

   function automatic op_t randomOp();
      op_t o;
      int  kind, size, off;
      o = baseOp();
      kind    = $urandom_range(0, 9);
      o.width = 4'b0001 << $urandom_range(0, 3);
      size    = sizeOf(o.width);
      off     = $urandom_range(0, 7);
      if (kind != 9) off = (off / size) * size;
      o.addr  = {$urandom, $urandom};
      o.addr[2:0] = 3'(off);
      o.rs2   = {$urandom, $urandom};
      o.rdv   = {$urandom, $urandom};
      o.rdata = {$urandom, $urandom};
      o.idx   = 5'($urandom_range(0, 31));
      o.wr_en = ($urandom_range(0, 4) != 0);
      o.sign  = 1'($urandom_range(0, 1));
      o.gnt_wait  = $urandom_range(0, 3);
      o.resp_wait = $urandom_range(1, 3);
      o.hold      = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2) : 0;
      if (kind <= 2) begin
         o.src = ($urandom_range(0, 1) == 0) ? 3'b001 : 3'b100;
      end else if (kind <= 5) begin
         o.rd = 1'b1; o.src = 3'b010;
      end else if (kind <= 7) begin
         o.wr = 1'b1;
      end else if (kind == 8) begin
         o.valid = 1'b0; o.rd = 1'($urandom_range(0, 1)); o.wr = 1'($urandom_range(0, 1));
      end else begin
         if ($urandom_range(0, 1) == 0) begin o.rd = 1'b1; o.src = 3'b010; end
         else o.wr = 1'b1;
      end
      return o;
   endfunction

   initial begin
      op_t o;
      int  s0, q0;

      rst = 1'b1; stall_down = 1'b0; valid_in = 1'b0; alu_res = '0; rs2_data = '0;
      rd_data_in = '0; rd_idx_in = '0; rd_wr_en_in = 1'b0; rd_src = 3'b001;
      mem_width = 4'b1000; mem_rd = 1'b0; mem_wr = 1'b0; mem_sign = 1'b0;
      gnt = 1'b0; rvalid = 1'b0; rdata = '0;
      exp_req = 1'b0; exp_stall = 1'b0; exp_we = 1'b0; exp_be = '0; exp_addr = '0; exp_wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      mdl_valid = 1'b0; mdl_wr_en = 1'b0; mdl_mis = 1'b0; mdl_idx = '0;
      mdl_data = '0; mdl_data_ok = 1'b1;
      exp_check = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;

      // model anchors
      checkOutput("model_lw", refLoad(64'h8765_4321_0000_0000, 4, 4, 1'b1), 64'hFFFF_FFFF_8765_4321);
      checkOutput("model_sb_be", 64'(refBe(3, 1)), 64'h08);
      checkOutput("model_lbu", refLoad(64'h0011_2233_4455_6677, 5, 1, 1'b0), 64'h22);

      // LW signed, immediate grant, response next cycle
      o = baseOp(); o.rd = 1'b1; o.sign = 1'b1; o.width = 4'b0100; o.src = 3'b010;
      o.addr = 64'h1004; o.rdata = 64'h8765_4321_0000_0000; o.idx = 5'd7;
      s0 = stall_cycles;
      applyStimulus(o);
      checkOutput("lw_be", 64'(seen_be), 64'hF0);
      checkOutput("lw_addr", seen_addr, 64'h1000);
      checkOutput("lw_rd_data", rd_data_out, 64'hFFFF_FFFF_8765_4321);
      checkOutput("lw_stall_cycles", 64'(stall_cycles - s0), 64'd1);

      // SB
      o = baseOp(); o.wr = 1'b1; o.width = 4'b0001; o.addr = 64'h2003; o.rs2 = 64'hAB;
      applyStimulus(o);
      checkOutput("sb_be", 64'(seen_be), 64'h08);
      checkOutput("sb_wdata", seen_wdata, 64'hAB00_0000);
      checkOutput("sb_we", 64'(seen_we), 64'd1);
      checkOutput("sb_rd_wr_en", 64'(rd_wr_en_out), 64'd0);

      // LH misaligned
      o = baseOp(); o.rd = 1'b1; o.width = 4'b0010; o.addr = 64'h3001; o.src = 3'b010;
      s0 = stall_cycles; q0 = req_cycles;
      applyStimulus(o);
      checkOutput("lh_mis_req", 64'(req_cycles - q0), 64'd0);
      checkOutput("lh_mis_stall", 64'(stall_cycles - s0), 64'd0);
      checkOutput("lh_mis_valid", 64'(valid_out), 64'd1);
      checkOutput("lh_mis_flag", 64'(misaligned_out), 64'd1);
      checkOutput("lh_mis_wr_en", 64'(rd_wr_en_out), 64'd0);

      // grant withheld for 3 cycles
      o = baseOp(); o.rd = 1'b1; o.src = 3'b010; o.addr = 64'h4A08;
      o.rdata = 64'h0123_4567_89AB_CDEF; o.gnt_wait = 3;
      q0 = req_cycles;
      applyStimulus(o);
      checkOutput("gnt_wait_req_cycles", 64'(req_cycles - q0), 64'd4);
      checkOutput("gnt_wait_rd_data", rd_data_out, 64'h0123_4567_89AB_CDEF);

      // response while writeback stalls for 2 cycles
      o = baseOp(); o.rd = 1'b1; o.src = 3'b010; o.width = 4'b0001; o.addr = 64'h4005;
      o.rdata = 64'h0011_2233_4455_6677; o.hold = 2; o.idx = 5'd9;
      applyStimulus(o);
      checkOutput("hold_rd_data", rd_data_out, 64'h22);
      checkOutput("hold_valid", 64'(valid_out), 64'd1);

      // reset while waiting for the response, then a stray response
      exp_check = 1'b0;
      valid_in = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0; mem_width = 4'b1000; alu_res = 64'h5000;
      rd_src = 3'b010; rd_wr_en_in = 1'b1; gnt = 1'b1; rvalid = 1'b0; stall_down = 1'b0;
      @(posedge clk);
      #1;
      gnt = 1'b0; rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("rst_valid", 64'(valid_out), 64'd0);
      checkOutput("rst_wr_en", 64'(rd_wr_en_out), 64'd0);
      checkOutput("rst_rd_data", rd_data_out, 64'd0);
      rst = 1'b0; valid_in = 1'b0; mem_rd = 1'b0; rd_idx_in = '0; rd_data_in = '0;
      rd_src = 3'b001; rd_wr_en_in = 1'b0; rvalid = 1'b1; rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      #3;
      checkOutput("rst_stray_req", 64'(req), 64'd0);
      checkOutput("rst_stray_stall", 64'(stall_up), 64'd0);
      @(posedge clk);
      #1;
      rvalid = 1'b0;
      checkOutput("rst_stray_valid", 64'(valid_out), 64'd0);
      checkOutput("rst_stray_wr_en", 64'(rd_wr_en_out), 64'd0);
      mdl_valid = 1'b0; mdl_wr_en = 1'b0; mdl_mis = 1'b0; mdl_idx = '0;
      mdl_data = '0; mdl_data_ok = 1'b1;
      exp_req = 1'b0; exp_stall = 1'b0;
      exp_check = 1'b1;

      // randomized traffic
      for (int n = 0; n < 300; n++) begin
         applyStimulus(randomOp());
      end

      exp_check = 1'b0;
      @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
